// File: rtl/einstein_kb_pkg.sv
// Shared types and constants for the Einstein PS/2 keyboard adapter.
package einstein_kb_pkg;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;
    localparam int unsigned PAUSE_SKIP  = 7;

    localparam int unsigned N_IGNORED = 4;
    localparam logic [N_IGNORED-1:0][7:0] IGNORED_CODES = {8'hAA, 8'hFA, 8'hFC, 8'hEE};

    typedef enum logic [1:0] {ModLShift, ModRShift, ModCtrl, ModGraph} mod_id_e;

    typedef struct packed {
        logic       valid;
        logic       is_mod;
        mod_id_e    mod_id;
        logic [2:0] row;
        logic [2:0] col;
    } map_result_t;

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_IGNORED; i++) begin
            if (code == IGNORED_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic map_result_t mk_key(input logic [2:0] row, input logic [2:0] col);
        map_result_t r;
        r.valid  = 1'b1;
        r.is_mod = 1'b0;
        r.mod_id = ModLShift;
        r.row    = row;
        r.col    = col;
        return r;
    endfunction

    function automatic map_result_t mk_mod(input mod_id_e id);
        map_result_t r;
        r.valid  = 1'b1;
        r.is_mod = 1'b1;
        r.mod_id = id;
        r.row    = 3'd0;
        r.col    = 3'd0;
        return r;
    endfunction

endpackage

// File: rtl/einstein_kbd_map.sv
// Scancode set 2 to Einstein matrix position / modifier lookup (combinational).
module einstein_kbd_map
    import einstein_kb_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  code,
    output map_result_t result
);

    always_comb begin
        result = '0;
        result.mod_id = ModLShift;
        if (ext) begin
            case (code)
                8'h75:   result = mk_key(3'd7, 3'd0);
                8'h72:   result = mk_key(3'd7, 3'd1);
                8'h6B:   result = mk_key(3'd7, 3'd2);
                8'h74:   result = mk_key(3'd7, 3'd3);
                8'h5A:   result = mk_key(3'd0, 3'd1);
                8'h14:   result = mk_mod(ModCtrl);
                8'h11:   result = mk_mod(ModGraph);
                default: ;
            endcase
        end else begin
            case (code)
                8'h29:   result = mk_key(3'd0, 3'd0);
                8'h5A:   result = mk_key(3'd0, 3'd1);
                8'h66:   result = mk_key(3'd0, 3'd2);
                8'h76:   result = mk_key(3'd0, 3'd3);
                8'h0D:   result = mk_key(3'd0, 3'd4);
                8'h15:   result = mk_key(3'd1, 3'd0);
                8'h1D:   result = mk_key(3'd1, 3'd1);
                8'h24:   result = mk_key(3'd1, 3'd2);
                8'h2D:   result = mk_key(3'd1, 3'd3);
                8'h2C:   result = mk_key(3'd1, 3'd4);
                8'h35:   result = mk_key(3'd1, 3'd5);
                8'h3C:   result = mk_key(3'd1, 3'd6);
                8'h43:   result = mk_key(3'd1, 3'd7);
                8'h44:   result = mk_key(3'd2, 3'd0);
                8'h1C:   result = mk_key(3'd2, 3'd1);
                8'h1B:   result = mk_key(3'd2, 3'd2);
                8'h23:   result = mk_key(3'd2, 3'd3);
                8'h2B:   result = mk_key(3'd2, 3'd4);
                8'h34:   result = mk_key(3'd2, 3'd5);
                8'h33:   result = mk_key(3'd2, 3'd6);
                8'h3B:   result = mk_key(3'd2, 3'd7);
                8'h42:   result = mk_key(3'd3, 3'd0);
                8'h4B:   result = mk_key(3'd3, 3'd1);
                8'h1A:   result = mk_key(3'd3, 3'd2);
                8'h22:   result = mk_key(3'd3, 3'd3);
                8'h21:   result = mk_key(3'd3, 3'd4);
                8'h2A:   result = mk_key(3'd3, 3'd5);
                8'h32:   result = mk_key(3'd3, 3'd6);
                8'h31:   result = mk_key(3'd3, 3'd7);
                8'h3A:   result = mk_key(3'd4, 3'd0);
                8'h4D:   result = mk_key(3'd4, 3'd1);
                8'h41:   result = mk_key(3'd4, 3'd2);
                8'h49:   result = mk_key(3'd4, 3'd3);
                8'h4A:   result = mk_key(3'd4, 3'd4);
                8'h16:   result = mk_key(3'd5, 3'd0);
                8'h1E:   result = mk_key(3'd5, 3'd1);
                8'h26:   result = mk_key(3'd5, 3'd2);
                8'h25:   result = mk_key(3'd5, 3'd3);
                8'h2E:   result = mk_key(3'd5, 3'd4);
                8'h36:   result = mk_key(3'd5, 3'd5);
                8'h3D:   result = mk_key(3'd5, 3'd6);
                8'h3E:   result = mk_key(3'd5, 3'd7);
                8'h46:   result = mk_key(3'd6, 3'd0);
                8'h45:   result = mk_key(3'd6, 3'd1);
                8'h4E:   result = mk_key(3'd6, 3'd2);
                8'h55:   result = mk_key(3'd6, 3'd3);
                8'h12:   result = mk_mod(ModLShift);
                8'h59:   result = mk_mod(ModRShift);
                8'h14:   result = mk_mod(ModCtrl);
                8'h11:   result = mk_mod(ModGraph);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/einstein_ps2_kbd.sv
// PS/2 keyboard receiver that emulates the Einstein 8x8 key matrix and modifier lines.
module einstein_ps2_kbd
    import einstein_kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] kb_row,
    output logic [7:0] kb_col,
    output logic       kb_shift,
    output logic       kb_ctrl,
    output logic       kb_graph,
    output logic       rx_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s, ps2_data_s, fall;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= (clk_sync_q << 1) | SYNC_STAGES'(ps2_clk);
            data_sync_q <= (data_sync_q << 1) | SYNC_STAGES'(ps2_data);
            clk_prev_q  <= ps2_clk_s;
        end
    end

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_vld_q, byte_vld_d;
    logic          rx_error_q, rx_error_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            byte_vld_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            rx_error_q <= rx_error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        byte_vld_d = 1'b0;
        rx_error_d = 1'b0;
        tmo_d      = (state_q == StIdle || fall) ? '0 : tmo_q + TW'(1);
        if (state_q != StIdle && tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_d    = StIdle;
            shreg_d    = '0;
            rx_error_d = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!ps2_data_s) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
                StData: begin
                    shreg_d   = {ps2_data_s, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = ps2_data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if ((^{shreg_q, parity_q}) && ps2_data_s) byte_vld_d = 1'b1;
                    else rx_error_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign rx_error = rx_error_q;

    logic              ext_q, ext_d, brk_q, brk_d;
    logic [2:0]        skip_q, skip_d;
    logic [7:0][7:0]   matrix_q, matrix_d;
    logic [3:0]        mods_q, mods_d;
    map_result_t       map_res;

    einstein_kbd_map u_map (
        .ext    (ext_q),
        .code   (shreg_q),
        .result (map_res)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            skip_q   <= '0;
            matrix_q <= '0;
            mods_q   <= '0;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            skip_q   <= skip_d;
            matrix_q <= matrix_d;
            mods_q   <= mods_d;
        end
    end

    // shreg_q still holds the completed byte in the cycle byte_vld_q is high.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        matrix_d = matrix_q;
        mods_d   = mods_q;
        if (rx_error_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_vld_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shreg_q == PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (shreg_q == PREFIX_BRK) begin
                brk_d = 1'b1;
            end else if (shreg_q == PREFIX_PAUSE) begin
                skip_d = 3'(PAUSE_SKIP);
            end else if (!is_ignored(shreg_q)) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (map_res.valid) begin
                    if (map_res.is_mod) mods_d[map_res.mod_id] = ~brk_q;
                    else matrix_d[map_res.row][map_res.col] = ~brk_q;
                end
            end
        end
    end

    logic [7:0] col_hit;
    logic [7:0] kb_col_q;

    always_comb begin
        col_hit = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                col_hit[c] = col_hit[c] | (~kb_row[r] & matrix_q[r][c]);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) kb_col_q <= 8'hFF;
        else kb_col_q <= ~col_hit;
    end

    assign kb_col   = kb_col_q;
    assign kb_shift = ~(mods_q[ModLShift] | mods_q[ModRShift]);
    assign kb_ctrl  = ~mods_q[ModCtrl];
    assign kb_graph = ~mods_q[ModGraph];

endmodule

// File: tb/tb_einstein_ps2_kbd.sv
// Directed self-checking bench for the Einstein PS/2 keyboard adapter.
module tb_einstein_ps2_kbd;
    import einstein_kb_pkg::*;

    localparam int unsigned HALF = 20;

    logic       clk_sys  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kb_row   = 8'hFF;
    logic [7:0] kb_col;
    logic       kb_shift, kb_ctrl, kb_graph, rx_error;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    einstein_ps2_kbd dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kb_row   (kb_row),
        .kb_col   (kb_col),
        .kb_shift (kb_shift),
        .kb_ctrl  (kb_ctrl),
        .kb_graph (kb_graph),
        .rx_error (rx_error)
    );

    always #25 clk_sys = ~clk_sys;

    always @(negedge clk_sys) if (rx_error) err_pulses++;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        wait_clks(2 * HALF);
    endtask

    task automatic test_reset;
        kb_row = 8'h00;
        wait_clks(5);
        checks++;
        if (kb_col !== 8'hFF) begin
            errors++; $display("FAIL reset_col: got %h want ff", kb_col);
        end
        checks++;
        if ({kb_shift, kb_ctrl, kb_graph, rx_error} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_mods: got %b want 1110", {kb_shift, kb_ctrl, kb_graph, rx_error});
        end
        reset_n = 1'b1;
        kb_row  = 8'hFF;
        wait_clks(5);
    endtask

    task automatic test_make_break;
        int e0;
        e0 = err_pulses;
        kb_row = 8'hFB;
        send_byte(8'h1C, 1'b0);
        checks++;
        if (kb_col !== 8'hFD) begin errors++; $display("FAIL make_a: got %h want fd", kb_col); end
        kb_row = 8'hFE;
        wait_clks(2);
        checks++;
        if (kb_col !== 8'hFF) begin errors++; $display("FAIL other_row: got %h want ff", kb_col); end
        kb_row = 8'hFB;
        wait_clks(1);
        checks++;
        if (kb_col !== 8'hFD) begin errors++; $display("FAIL row_latency: got %h want fd", kb_col); end
        send_byte(8'h1C, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        checks++;
        if (kb_col !== 8'hFF) begin errors++; $display("FAIL break_a: got %h want ff", kb_col); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        checks++;
        if (kb_col !== 8'hFF || err_pulses != e0) begin
            errors++; $display("FAIL break_unheld: col %h err %0d want ff 0", kb_col, err_pulses - e0);
        end
    endtask

    task automatic test_bad_parity;
        int e0;
        e0 = err_pulses;
        kb_row = 8'hFB;
        send_byte(8'h1C, 1'b1);
        checks++;
        if (err_pulses - e0 != 1) begin
            errors++; $display("FAIL parity_err: got %0d pulses want 1", err_pulses - e0);
        end
        checks++;
        if (kb_col !== 8'hFF) begin errors++; $display("FAIL parity_col: got %h want ff", kb_col); end
        // A break prefix must not survive a corrupted frame.
        send_byte(8'hF0, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h1C, 1'b0);
        checks++;
        if (kb_col !== 8'hFD) begin errors++; $display("FAIL prefix_clear: got %h want fd", kb_col); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
    endtask

    task automatic test_modifiers;
        send_byte(8'h12, 1'b0);
        send_byte(8'h59, 1'b0);
        checks++;
        if (kb_shift !== 1'b0) begin errors++; $display("FAIL both_shift: got %b want 0", kb_shift); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);
        checks++;
        if (kb_shift !== 1'b0) begin errors++; $display("FAIL rshift_held: got %b want 0", kb_shift); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h59, 1'b0);
        checks++;
        if (kb_shift !== 1'b1) begin errors++; $display("FAIL shift_rel: got %b want 1", kb_shift); end
        send_byte(8'hE0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h11, 1'b0);
        checks++;
        if ({kb_ctrl, kb_graph} !== 2'b00) begin
            errors++; $display("FAIL ctrl_graph: got %b want 00", {kb_ctrl, kb_graph});
        end
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h11, 1'b0);
        checks++;
        if ({kb_shift, kb_ctrl, kb_graph} !== 3'b111) begin
            errors++;
            $display("FAIL mods_rel: got %b want 111", {kb_shift, kb_ctrl, kb_graph});
        end
    endtask

    task automatic test_timeout;
        int e0;
        logic [7:0] b;
        e0 = err_pulses;
        b = 8'h29;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
        wait_clks(20100);
        checks++;
        if (err_pulses - e0 != 1) begin
            errors++; $display("FAIL timeout_err: got %0d pulses want 1", err_pulses - e0);
        end
        checks++;
        if (dut.state_q !== StIdle) begin
            errors++; $display("FAIL timeout_idle: got %0d want %0d", dut.state_q, StIdle);
        end
        kb_row = 8'hFE;
        send_byte(8'h29, 1'b0);
        checks++;
        if (kb_col !== 8'hFE) begin errors++; $display("FAIL after_tmo: got %h want fe", kb_col); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h29, 1'b0);
        checks++;
        if (kb_col !== 8'hFF) begin errors++; $display("FAIL space_rel: got %h want ff", kb_col); end
    endtask

    task automatic test_pause;
        int e0;
        e0 = err_pulses;
        kb_row = 8'h00;
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        checks++;
        if (kb_ctrl !== 1'b1) begin errors++; $display("FAIL pause_ctrl: got %b want 1", kb_ctrl); end
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        checks++;
        if (kb_col !== 8'hFF || {kb_shift, kb_ctrl, kb_graph} !== 3'b111 || err_pulses != e0) begin
            errors++;
            $display("FAIL pause_seq: col %h mods %b err %0d want ff 111 0", kb_col,
                     {kb_shift, kb_ctrl, kb_graph}, err_pulses - e0);
        end
        kb_row = 8'hFB;
        send_byte(8'h1C, 1'b0);
        checks++;
        if (kb_col !== 8'hFD) begin errors++; $display("FAIL pause_end: got %h want fd", kb_col); end
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
    endtask

    task automatic test_back_to_back_reset;
        send_byte(8'h1C, 1'b0);
        send_byte(8'h29, 1'b0);
        send_byte(8'h12, 1'b0);
        kb_row = 8'hFA;
        wait_clks(2);
        checks++;
        if (kb_col !== 8'hFC) begin errors++; $display("FAIL multi_row: got %h want fc", kb_col); end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        wait_clks(2);
        checks++;
        if (kb_col !== 8'hFF || {kb_shift, kb_ctrl, kb_graph} !== 3'b111) begin
            errors++;
            $display("FAIL midframe_rst: col %h mods %b want ff 111", kb_col,
                     {kb_shift, kb_ctrl, kb_graph});
        end
        ps2_data = 1'b1;
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(5);
        kb_row = 8'hFE;
        send_byte(8'h29, 1'b0);
        checks++;
        if (kb_col !== 8'hFE) begin errors++; $display("FAIL resume: got %h want fe", kb_col); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_bad_parity();
        test_modifiers();
        test_timeout();
        test_pause();
        test_back_to_back_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/einstein_ps2_kbd.md
EINSTEIN_PS2_KBD -- requirements
Module: einstein_ps2_kbd

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000, max clk_sys cycles between PS/2 falling edges inside a frame (1 ms at 20 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, flops per PS/2 input synchroniser.
REQ-003 clk_sys  in  1  system clock (20 MHz); sole clock; PS/2 lines sampled on it.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ps2_clk  in  1  raw PS/2 clock, asynchronous.
REQ-006 ps2_data  in  1  raw PS/2 data, asynchronous.
REQ-007 kb_row  in  8  row select from PSG port A, active-low.
REQ-008 kb_col  out  8  column sense to PSG port B, active-low (0 = key pressed).
REQ-009 kb_shift / kb_ctrl / kb_graph  out  1 each  modifier state, active-low.
REQ-010 rx_error  out  1  one-cycle pulse on a parity, start, stop or timeout fault.

Function
REQ-011 Each PS/2 line SHALL pass through SYNC_STAGES flops; a falling edge SHALL be detected on the synchronised ps2_clk.
REQ-012 The receiver FSM SHALL use states IDLE, DATA, PARITY, STOP, sampling ps2_data on each detected falling edge.
- IDLE->DATA when start bit = 0; start = 1 raises rx_error and stays in IDLE.
- DATA: shift 8 bits LSB first, then go to PARITY.
- PARITY: capture the bit, then go to STOP.
- STOP: the frame is valid only if odd parity holds over data+parity and stop = 1; either way return to IDLE.
REQ-013 A timeout counter SHALL reset on every falling edge; in any non-IDLE state, reaching TIMEOUT_CYCLES SHALL force IDLE, discard the partial byte and pulse rx_error.
REQ-014 An invalid frame SHALL pulse rx_error, discard the byte and clear the E0/F0 prefix flags.
REQ-015 Byte decode, applied one cycle after STOP:
- 0xE0 sets ext.
- 0xF0 sets brk.
- 0xE1 loads skip=7; the next 7 bytes are ignored.
- 0xAA, 0xFA, 0xFC, 0xEE are ignored.
- Any other byte is a key event {ext, brk, code}; ext and brk clear after the event.
REQ-016 Each key event SHALL be looked up in the map; a matrix key sets matrix[row][col] = brk ? 0 : 1 (1 = pressed); a modifier updates its modifier flop; an unmapped code has no effect.
REQ-017 Left and right shift SHALL be tracked separately; kb_shift = ~(lshift | rshift).
REQ-018 Mapping: ctrl = 0x14 with or without E0; graph = 0x11 with or without E0.
REQ-019 Registered output, 1-cycle latency from kb_row or matrix change: kb_col[c] = ~OR over r of (~kb_row[r] & matrix[r][c]). kb_row = 0xFF yields kb_col = 0xFF; multiple low rows OR their columns together.
REQ-020 A repeated make for a held key (typematic) SHALL leave state unchanged; a break for a key not held SHALL be harmless.
REQ-021 A matrix update and a kb_row change in the same cycle SHALL both be reflected on kb_col in the next cycle.

Reset
REQ-022 While reset_n = 0:
- FSM = IDLE.
- Shift register, counters, ext, brk and skip cleared.
- All matrix bits and modifiers released.
- kb_col = 0xFF; kb_shift = kb_ctrl = kb_graph = 1; rx_error = 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame; reception resumes at the next start bit after release.

Structure
REQ-024 Package einstein_kb_pkg SHALL hold:
- the receiver state enum;
- prefix constants 0xE0, 0xF0, 0xE1;
- the ignored-code list;
- modifier IDs;
- the map-result struct {valid, is_mod, mod_id, row[2:0], col[2:0]}.
REQ-025 One combinational sub-module, einstein_kbd_map ({ext, code[7:0]} -> map-result), SHALL hold the scancode table, including 0x1C (A) -> row 2, col 1 and 0x29 (space) -> row 0, col 0.

Verification
REQ-026 Send 0x1C, hold kb_row = 0xFB -> kb_col = 0xFD one cycle later; send F0 1C -> kb_col = 0xFF.
REQ-027 Send 0x1C with a bad parity bit -> rx_error pulses once, kb_col stays 0xFF for kb_row = 0xFB.
REQ-028 Send 0x12 then 0x59, then F0 12 -> kb_shift stays 0; after F0 59 -> kb_shift = 1.
REQ-029 Stop ps2_clk after 4 data bits for more than 20000 cycles -> rx_error pulses, FSM is IDLE; the next full 0x29 frame with kb_row = 0xFE -> kb_col = 0xFE.
REQ-030 Press A and space, drive kb_row = 0xFA -> kb_col = 0xFC; assert reset_n = 0 mid-frame -> kb_col = 0xFF and all modifiers = 1.
REQ-031 Send E1 14 77 E1 F0 14 F0 77 -> no matrix or modifier change and no rx_error.
